// File: rtl/branch_issue_sched.sv
// rtl/branch_issue_sched.sv - splits a 4-slot bundle into issue groups holding at most one branch
module branch_issue_sched #(
  parameter logic [3:0] BR_OP = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [15:0] in_ops,
  input  logic [3:0]  in_slot_vld,
  input  logic        flush,
  output logic        iss_vld,
  input  logic        iss_rdy,
  output logic [3:0]  iss_mask,
  output logic        busy,
  output logic [7:0]  stall_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  p_q, p_d;
  logic [15:0] ops_q, ops_d;
  logic [7:0]  stall_q, stall_d;

  logic [3:0]  grp;
  logic        accept;
  logic        iss_hs;
  logic [3:0]  p_after;

  // Group = pending slots from oldest upward, stopping before the second pending branch
  always_comb begin
    logic br_seen;
    logic stop;
    grp     = 4'b0000;
    br_seen = 1'b0;
    stop    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p_q[i] && !stop) begin
        if (ops_q[4*i +: 4] == BR_OP) begin
          if (br_seen) begin
            stop = 1'b1;
          end else begin
            br_seen = 1'b1;
            grp[i]  = 1'b1;
          end
        end else begin
          grp[i] = 1'b1;
        end
      end
    end
  end

  // Handshake qualifiers shared by next-state and output logic
  always_comb begin
    accept  = in_vld & (state_q == IDLE) & ~flush;
    iss_hs  = (state_q == ISSUE) & iss_rdy;
    p_after = p_q & ~grp;
  end

  // State and datapath registers; rst dominates everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= 4'b0000;
      ops_q   <= 16'h0000;
      stall_q <= 8'h00;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  // Next-state: flush first, then bundle load in IDLE, then group retirement in ISSUE
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ops_d   = ops_q;
    stall_d = stall_q;
    if (flush) begin
      state_d = IDLE;
      p_d     = 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_vld) begin
            p_d     = in_slot_vld;
            ops_d   = in_ops;
            state_d = (in_slot_vld != 4'b0000) ? ISSUE : IDLE;
          end
        end
        ISSUE: begin
          if (iss_hs) begin
            p_d = p_after;
            if (p_after == 4'b0000) begin
              state_d = IDLE;
            end else if (stall_q != 8'hFF) begin
              stall_d = stall_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          p_d     = 4'b0000;
        end
      endcase
    end
  end

  // Outputs depend on registered state, except in_rdy which is gated by flush
  always_comb begin
    in_rdy    = (state_q == IDLE) & ~flush;
    iss_vld   = (state_q == ISSUE);
    iss_mask  = (state_q == ISSUE) ? grp : 4'b0000;
    busy      = (p_q != 4'b0000);
    stall_cnt = stall_q;
  end

  logic unused_accept;
  always_comb unused_accept = accept;

endmodule

// File: tb/tb_branch_issue_sched.sv
// tb/tb_branch_issue_sched.sv - vector table, corner sequences and random model check for branch_issue_sched
module tb_branch_issue_sched;

  localparam logic [3:0] BR = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [15:0] in_ops;
  logic [3:0]  in_slot_vld;
  logic        flush;
  logic        iss_vld;
  logic        iss_rdy;
  logic [3:0]  iss_mask;
  logic        busy;
  logic [7:0]  stall_cnt;

  int tests = 0;
  int fails = 0;
  int exp_stall = 0;

  branch_issue_sched #(.BR_OP(BR)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_ops(in_ops),
    .in_slot_vld(in_slot_vld), .flush(flush), .iss_vld(iss_vld), .iss_rdy(iss_rdy),
    .iss_mask(iss_mask), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  slot_vld;
    logic [15:0] ops;
    int          n;
    logic [15:0] masks;   // group k in nibble k
    int          stalls;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [15:0] m;
    m = v.masks;
    in_vld = 1'b1; in_ops = v.ops; in_slot_vld = v.slot_vld; iss_rdy = 1'b1; flush = 1'b0;
    #1;
    chk("vec_in_rdy", in_rdy, 1);
    tick();
    in_vld = 1'b0;
    #1;
    for (int k = 0; k < v.n; k++) begin
      chk("vec_iss_vld", iss_vld, 1);
      chk("vec_mask", iss_mask, m[4*k +: 4]);
      chk("vec_busy", busy, 1);
      chk("vec_in_rdy_busy", in_rdy, 0);
      tick();
    end
    exp_stall = sat_add(exp_stall, v.stalls);
    chk("vec_done_vld", iss_vld, 0);
    chk("vec_done_busy", busy, 0);
    chk("vec_done_rdy", in_rdy, 1);
    chk("vec_stall", stall_cnt, exp_stall);
  endtask

  // Reference grouping: walk pending slot indices oldest first, stop at the second branch
  int          q[$];
  logic [3:0]  m_ops [4];

  function automatic logic [3:0] model_group(output int cnt);
    int brs;
    logic [3:0] g;
    brs = 0; g = 4'b0000; cnt = 0;
    foreach (q[j]) begin
      if (m_ops[q[j]] == BR) begin
        if (brs == 1) break;
        brs++;
      end
      g[q[j]] = 1'b1;
      cnt++;
    end
    return g;
  endfunction

  initial begin
    vecs[0] = '{4'b1111, 16'h2222, 1, 16'h000F, 0};
    vecs[1] = '{4'b1111, 16'h1211, 3, 16'h0861, 2};
    vecs[2] = '{4'b1110, 16'h1211, 2, 16'h0086, 1};
    vecs[3] = '{4'b0000, 16'h1111, 0, 16'h0000, 0};
    vecs[4] = '{4'b0101, 16'h1111, 2, 16'h0041, 1};
    vecs[5] = '{4'b1010, 16'h2222, 1, 16'h000A, 0};
    vecs[6] = '{4'b1111, 16'h1111, 4, 16'h8421, 3};
    vecs[7] = '{4'b1001, 16'h1221, 2, 16'h0081, 1};

    rst = 1'b1; in_vld = 1'b0; in_ops = '0; in_slot_vld = '0; flush = 1'b0; iss_rdy = 1'b0;
    tick(); tick();
    chk("rst_iss_vld", iss_vld, 0);
    chk("rst_mask", iss_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b0;
    flush = 1'b1; #1;
    chk("rst_in_rdy_flush", in_rdy, 0);
    flush = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // downstream back-pressure holds the group
    in_vld = 1'b1; in_ops = 16'h1211; in_slot_vld = 4'b1111; iss_rdy = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("hold_vld", iss_vld, 1);
      chk("hold_mask", iss_mask, 4'b0001);
      chk("hold_in_rdy", in_rdy, 0);
      chk("hold_busy", busy, 1);
      tick();
    end
    in_vld = 1'b0; iss_rdy = 1'b1; #1;
    chk("hold_rel0", iss_mask, 4'b0001); tick();
    chk("hold_rel1", iss_mask, 4'b0110); tick();
    chk("hold_rel2", iss_mask, 4'b1000); tick();
    exp_stall = sat_add(exp_stall, 2);
    chk("hold_stall", stall_cnt, exp_stall);

    // flush after the first of three groups; coincident handshake must not count
    in_vld = 1'b1; in_ops = 16'h1211; in_slot_vld = 4'b1111; iss_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    exp_stall = sat_add(exp_stall, 1);
    chk("flush_pre_mask", iss_mask, 4'b0110);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("flush_vld", iss_vld, 0);
    chk("flush_busy", busy, 0);
    chk("flush_rdy", in_rdy, 1);
    chk("flush_stall", stall_cnt, exp_stall);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_issue", iss_mask, 0);
    end

    // rst mid-ISSUE with stall_cnt at 5
    rst = 1'b1; tick(); rst = 1'b0; exp_stall = 0;
    run_vec(vecs[6]);
    run_vec(vecs[4]);
    in_vld = 1'b1; in_ops = 16'h1111; in_slot_vld = 4'b1111; iss_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    chk("rstmid_stall5", stall_cnt, 5);
    chk("rstmid_vld", iss_vld, 1);
    rst = 1'b1; iss_rdy = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rstmid_iss_vld", iss_vld, 0);
    chk("rstmid_mask", iss_mask, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rdy", in_rdy, 1);
    chk("rstmid_stall", stall_cnt, 0);
    tick();
    chk("rstmid_no_issue", iss_vld, 0);
    exp_stall = 0;

    // randomized traffic against the queue model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] g;
      int cnt;
      logic e_rdy;
      in_vld = 1'($urandom % 2);
      in_slot_vld = 4'($urandom);
      for (int s = 0; s < 4; s++)
        in_ops[4*s +: 4] = ($urandom % 2) ? BR : 4'($urandom);
      flush = (($urandom % 16) == 0);
      iss_rdy = (($urandom % 4) != 0);
      #1;
      g = model_group(cnt);
      e_rdy = (q.size() == 0) && !flush;
      chk("rnd_in_rdy", in_rdy, e_rdy);
      chk("rnd_iss_vld", iss_vld, q.size() != 0);
      chk("rnd_mask", iss_mask, (q.size() != 0) ? g : 4'b0000);
      chk("rnd_busy", busy, q.size() != 0);
      chk("rnd_stall", stall_cnt, exp_stall);
      if (flush) begin
        q.delete();
      end else if (e_rdy && in_vld) begin
        for (int s = 0; s < 4; s++) begin
          m_ops[s] = in_ops[4*s +: 4];
          if (in_slot_vld[s]) q.push_back(s);
        end
      end else if (q.size() != 0 && iss_rdy) begin
        for (int k = 0; k < cnt; k++) void'(q.pop_front());
        if (q.size() != 0) exp_stall = sat_add(exp_stall, 1);
      end
      tick();
    end
    flush = 1'b1; in_vld = 1'b0; tick(); flush = 1'b0; q.delete();

    // saturation at 255
    for (int r = 0; r < 90; r++) run_vec(vecs[6]);
    chk("sat_stall", stall_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_issue_sched.md
BRANCH_ISSUE_SCHED -- requirements
Module: branch_issue_sched

Interface
REQ-001 SHALL have parameter BR_OP, default 4'b0001, the opcode that marks a branch.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_vld  input  1  a 4-slot bundle is offered.
REQ-005 SHALL have port in_rdy  output  1  the scheduler accepts a bundle this cycle.
REQ-006 SHALL have port in_ops  input  16  slot i opcode at [4i+3:4i]; slot 0 is oldest.
REQ-007 SHALL have port in_slot_vld  input  4  per-slot valid; bit i is slot i.
REQ-008 SHALL have port flush  input  1  discards all pending slots.
REQ-009 SHALL have port iss_vld  output  1  an issue group is presented.
REQ-010 SHALL have port iss_rdy  input  1  downstream accepts the presented group.
REQ-011 SHALL have port iss_mask  output  4  slots in the presented group.
REQ-012 SHALL have port busy  output  1  high while pending slots remain.
REQ-013 SHALL have port stall_cnt  output  8  count of extra issue cycles caused by branch splitting.

Function
REQ-014 SHALL implement states IDLE and ISSUE, plus a registered 4-bit pending mask P and registered copies of the bundle opcodes.
REQ-015 SHALL drive in_rdy = (state==IDLE) & ~flush.
REQ-016 SHALL, on in_vld & in_rdy, load P <= in_slot_vld and the opcodes; if in_slot_vld != 0, SHALL go to ISSUE, otherwise SHALL stay in IDLE.
REQ-017 SHALL drive iss_vld = (state==ISSUE); the first iss_vld is one cycle after bundle acceptance.
REQ-018 SHALL form the group from pending slots in ascending index, up to but excluding the second pending slot whose opcode == BR_OP.
REQ-019 SHALL therefore place at most one branch in a group; a non-pending slot SHALL never be in the group and SHALL never count as a branch.
REQ-020 SHALL drive iss_mask equal to the group when iss_vld is high and 4'b0000 otherwise; iss_mask SHALL be derived from registered state only.
REQ-021 SHALL, on iss_vld & iss_rdy, update P <= P & ~iss_mask; if the result is 0, SHALL return to IDLE, otherwise SHALL stay in ISSUE.
REQ-022 SHALL hold iss_mask, iss_vld and P unchanged while iss_vld & ~iss_rdy.
REQ-023 SHALL increment stall_cnt on each issue handshake that leaves P != 0.
REQ-024 SHALL saturate stall_cnt at 255; flush SHALL NOT clear stall_cnt.
REQ-025 SHALL drive busy = (P != 0).
REQ-026 SHALL treat flush as highest priority after rst: P <= 0 and state <= IDLE at the next edge, with no bundle accepted that cycle.
REQ-027 SHALL NOT increment stall_cnt on a handshake that coincides with flush.
REQ-028 SHALL NOT accept a new bundle before the cycle after the last group's handshake; there is no same-cycle refill.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set state=IDLE, P=0, the opcode registers=0 and stall_cnt=0.
REQ-030 SHALL give these outputs after reset: iss_vld=0, iss_mask=0, busy=0, in_rdy=1 (unless flush is high).
REQ-031 SHALL, when rst is asserted mid-ISSUE, abort the bundle with no further issue.
REQ-032 SHALL give rst priority over flush, in_vld and iss_rdy.

Verification
REQ-033 SHALL cover: 4 valid ALU ops (opcode 0010), iss_rdy=1 -> single iss_mask=1111 at N+1; IDLE at N+2; stall_cnt=0.
REQ-034 SHALL cover: ops BR,BR,ALU,BR all valid, iss_rdy=1 -> iss_mask 0001, then 0110, then 1000 on consecutive cycles; stall_cnt=2.
REQ-035 SHALL cover: in_slot_vld=1110, slot0 BR (invalid), slot1 BR, slot2 ALU, slot3 BR -> iss_mask 0110, then 1000; stall_cnt=1.
REQ-036 SHALL cover: iss_rdy held low 3 cycles during ISSUE -> iss_mask stable, iss_vld=1, in_rdy=0, busy=1 throughout.
REQ-037 SHALL cover: flush in the cycle after the first of three groups -> next cycle iss_vld=0, busy=0, in_rdy=1; the remaining slots are never issued.
REQ-038 SHALL cover: rst pulsed mid-ISSUE with stall_cnt=5 -> next cycle all outputs at reset values and stall_cnt=0.
